// File: rtl/eh2_ram_init_be.sv
`timescale 1ns/1ps
// Single-port RAM with per-lane write mask and a self-running init sweep that fills every word with INIT_VAL.
// Latency: read data one cycle after the accepted read; two cycles when EH2_RAM_RD_PIPE_EN is defined.
// Backpressure: none; accesses that arrive while busy (sweep running) are dropped without a response.
module eh2_ram_init_be #(
  parameter int               DEPTH    = 4096,
  parameter int               WIDTH    = 39,
  parameter int               GRAN     = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       me,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   adr,
  input  logic [WIDTH-1:0]           d,
  input  logic [WIDTH/GRAN-1:0]      wem,
  input  logic                       init_req,
  output logic [WIDTH-1:0]           q,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       init_done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = WIDTH / GRAN;

  // A lane width that does not divide the word leaves a partial lane with no mask bit.
  generate
    if (WIDTH % GRAN != 0) begin : g_bad_gran
      $error("eh2_ram_init_be: WIDTH must be a multiple of GRAN");
    end
  endgenerate

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic             r_init_done;
  logic             w_init_done_nxt;
  logic             w_adr_ok;
  logic             w_ptr_last;
  logic             w_sweep_wr;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q1;
  logic             r_v1;

  // Non-power-of-two depths leave an address hole above DEPTH-1.
  assign w_adr_ok   = (32'(adr) < DEPTH);
  assign w_ptr_last = (r_ptr == AW'(DEPTH - 1));
  assign init_done  = r_init_done;

  // State, sweep pointer and sticky done flag; reset restarts the sweep at address 0.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next state and per-cycle memory controls; init_req is only honoured in IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_init_done_nxt = r_init_done;
    busy            = 1'b0;
    w_sweep_wr      = 1'b0;
    w_wr            = 1'b0;
    w_rd            = 1'b0;
    case (r_state)
      ST_INIT: begin
        busy       = 1'b1;
        w_sweep_wr = 1'b1;
        if (w_ptr_last) begin
          w_state_nxt     = ST_IDLE;
          w_ptr_nxt       = '0;
          w_init_done_nxt = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + AW'(1);
        end
      end
      ST_IDLE: begin
        // The access in the same cycle as init_req still completes; the sweep overwrites it.
        w_wr = me & we & w_adr_ok;
        w_rd = me & ~we;
        if (init_req) begin
          w_state_nxt     = ST_INIT;
          w_ptr_nxt       = '0;
          w_init_done_nxt = 1'b0;
        end
      end
    endcase
  end

  // Memory array: sweep writes all lanes, normal writes only the masked lanes; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_sweep_wr) begin
      r_mem[r_ptr] <= INIT_VAL;
    end else if (w_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (wem[i]) begin
          r_mem[adr][i*GRAN +: GRAN] <= d[i*GRAN +: GRAN];
        end
      end
    end
  end

  // First read stage: out-of-range reads answer with zero; data holds when no read completes.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_rd;
      if (w_rd) begin
        r_q1 <= w_adr_ok ? r_mem[adr] : '0;
      end
    end
  end

`ifdef EH2_RAM_RD_PIPE_EN
  logic [WIDTH-1:0] r_q2;
  logic             r_v2;

  // Output register stage: data and valid move together, so back-to-back reads stay pipelined.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_q2 <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_q2 <= r_q1;
      end
    end
  end

  assign q        = r_q2;
  assign rd_valid = r_v2;
`else
  assign q        = r_q1;
  assign rd_valid = r_v1;
`endif

endmodule
